// File: rtl/rgb_fade_engine.sv
// Colour-fade sequencer: ramps three 8-bit LED channels one LSB per step toward a
// commanded target colour. It pulses done when the target is reached.
module rgb_fade_engine #(
    parameter int TICK_DIV = 12000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_r,
    input  logic [7:0] cmd_g,
    input  logic [7:0] cmd_b,
    input  logic [7:0] cmd_rate,
    input  logic       cmd_abort,
    output logic [7:0] led_r,
    output logic [7:0] led_g,
    output logic [7:0] led_b,
    output logic       busy,
    output logic       done
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

    typedef enum logic {
        IDLE = 1'b0,
        FADE = 1'b1
    } state_t;

    // Handshake: a command transfers on a rising edge where cmd_valid and cmd_ready
    // are both high. cmd_ready is high only in IDLE, and it is low through reset.
    state_t        state_q;
    logic [PW-1:0] presc_q;
    logic [7:0]    tick_cnt_q;
    logic [7:0]    rate_q;
    logic [7:0]    tgt_r_q, tgt_g_q, tgt_b_q;
    logic [7:0]    led_r_q, led_g_q, led_b_q;
    logic          busy_q, done_q, ready_q;

    logic          tick_d, step_d, arrived_d, cmd_match_d;
    logic [7:0]    led_r_d, led_g_d, led_b_d;

    function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
        logic [7:0] nxt;
        nxt = cur;
        if (cur < tgt) nxt = cur + 8'd1;
        else if (cur > tgt) nxt = cur - 8'd1;
        return nxt;
    endfunction

    always_comb begin
        tick_d      = (presc_q == PRESC_LAST);
        step_d      = tick_d && (tick_cnt_q == rate_q - 8'd1);
        led_r_d     = step_toward(led_r_q, tgt_r_q);
        led_g_d     = step_toward(led_g_q, tgt_g_q);
        led_b_d     = step_toward(led_b_q, tgt_b_q);
        arrived_d   = (led_r_d == tgt_r_q) && (led_g_d == tgt_g_q) && (led_b_d == tgt_b_q);
        cmd_match_d = (cmd_r == led_r_q) && (cmd_g == led_g_q) && (cmd_b == led_b_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            tick_cnt_q <= '0;
            rate_q     <= '0;
            tgt_r_q    <= '0;
            tgt_g_q    <= '0;
            tgt_b_q    <= '0;
            led_r_q    <= '0;
            led_g_q    <= '0;
            led_b_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (cmd_valid && ready_q) begin
                        tgt_r_q <= cmd_r;
                        tgt_g_q <= cmd_g;
                        tgt_b_q <= cmd_b;
                        rate_q  <= cmd_rate;
                        if (cmd_rate == 8'd0) begin
                            led_r_q <= cmd_r;
                            led_g_q <= cmd_g;
                            led_b_q <= cmd_b;
                            done_q  <= 1'b1;
                        end else if (cmd_match_d) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q    <= FADE;
                            busy_q     <= 1'b1;
                            ready_q    <= 1'b0;
                            presc_q    <= '0;
                            tick_cnt_q <= '0;
                        end
                    end
                end
                FADE: begin
                    // Abort takes priority over a step landing on the same edge.
                    if (cmd_abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        presc_q <= tick_d ? '0 : presc_q + PRESC_ONE;
                        if (step_d) begin
                            tick_cnt_q <= '0;
                            led_r_q    <= led_r_d;
                            led_g_q    <= led_g_d;
                            led_b_q    <= led_b_d;
                            if (arrived_d) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                ready_q <= 1'b1;
                                done_q  <= 1'b1;
                            end
                        end else if (tick_d) begin
                            tick_cnt_q <= tick_cnt_q + 8'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready = ready_q;
    assign led_r     = led_r_q;
    assign led_g     = led_g_q;
    assign led_b     = led_b_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_rgb_fade_engine.sv
// Directed bench for rgb_fade_engine (TICK_DIV=4). Edge n is the nth rising clock edge.
// Expected done events ({edge, rgb}) queue up at issue time, and a monitor retires them.
module tb_rgb_fade_engine;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_r = '0, cmd_g = '0, cmd_b = '0, cmd_rate = '0;
    logic       cmd_abort = 1'b0;
    logic [7:0] led_r, led_g, led_b;
    logic       busy, done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc      = 0;
    logic [55:0] exp_q[$];

    rgb_fade_engine #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_r(cmd_r), .cmd_g(cmd_g), .cmd_b(cmd_b),
        .cmd_rate(cmd_rate), .cmd_abort(cmd_abort),
        .led_r(led_r), .led_g(led_g), .led_b(led_b),
        .busy(busy), .done(done)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_state(input string tag, input logic [23:0] rgb, input logic bsy, input logic rdy);
        chk({tag, "_rgb"}, {8'h0, led_r, led_g, led_b}, {8'h0, rgb});
        chk({tag, "_busy"}, {31'h0, busy}, {31'h0, bsy});
        chk({tag, "_ready"}, {31'h0, cmd_ready}, {31'h0, rdy});
    endtask

    // driver: called at a falling edge; the command transfers on the next rising edge.
    // done_dly < 0 means no done pulse is expected for this command.
    task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                        input logic [7:0] rate, input logic abort, input int done_dly);
        chk("cmd_ready_before_send", {31'h0, cmd_ready}, 32'h1);
        cmd_valid = 1'b1;
        cmd_r = r; cmd_g = g; cmd_b = b; cmd_rate = rate; cmd_abort = abort;
        acc = cyc + 1;
        if (done_dly >= 0) exp_q.push_back({32'(acc + done_dly), r, g, b});
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_abort = 1'b0;
    endtask

    task automatic wait_until(input int edge_n);
        while (cyc < edge_n) @(negedge clk);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'h1, 32'h0);
            end else begin
                logic [55:0] e;
                e = exp_q.pop_front();
                chk("done_edge", 32'(cyc), e[55:24]);
                chk("done_rgb", {8'h0, led_r, led_g, led_b}, {8'h0, e[23:0]});
                chk("done_busy", {31'h0, busy}, 32'h0);
            end
        end
    end

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        chk_state("reset", 24'h000000, 1'b0, 1'b0);
        chk("reset_done", {31'h0, done}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_release", {31'h0, cmd_ready}, 32'h1);

        // immediate jump, back-to-back, abort ignored in IDLE
        send(8'h80, 8'h10, 8'hFF, 8'd0, 1'b0, 0);
        chk_state("jump1", 24'h8010FF, 1'b0, 1'b1);
        send(8'h11, 8'h22, 8'h33, 8'd0, 1'b0, 0);
        chk_state("jump2", 24'h112233, 1'b0, 1'b1);
        send(8'h20, 8'h30, 8'h40, 8'd0, 1'b1, 0);
        chk_state("jump_abort_idle", 24'h203040, 1'b0, 1'b1);
        send(8'h00, 8'h00, 8'h00, 8'd0, 1'b0, 0);
        @(negedge clk);

        // up-fade, rate 2: steps at 8, 16, 24 edges after acceptance
        send(8'd3, 8'd1, 8'd0, 8'd2, 1'b0, 24);
        chk_state("up_c0", 24'h000000, 1'b1, 1'b0);
        wait_until(acc + 7);  chk_state("up_c7", 24'h000000, 1'b1, 1'b0);
        wait_until(acc + 8);  chk_state("up_c8", 24'h010100, 1'b1, 1'b0);
        wait_until(acc + 15); chk_state("up_c15", 24'h010100, 1'b1, 1'b0);
        wait_until(acc + 16); chk_state("up_c16", 24'h020100, 1'b1, 1'b0);
        wait_until(acc + 23); chk_state("up_c23", 24'h020100, 1'b1, 1'b0);
        wait_until(acc + 24); chk_state("up_c24", 24'h030100, 1'b0, 1'b1);
        @(negedge clk);

        // down-fade with saturation, rate 1: a step every 4 edges
        send(8'hFF, 8'hFF, 8'hFF, 8'd0, 1'b0, 0);
        send(8'hFD, 8'hFF, 8'h00, 8'd1, 1'b0, 1020);
        wait_until(acc + 4);    chk_state("dn_c4", 24'hFEFFFE, 1'b1, 1'b0);
        wait_until(acc + 8);    chk_state("dn_c8", 24'hFDFFFD, 1'b1, 1'b0);
        wait_until(acc + 12);   chk_state("dn_c12", 24'hFDFFFC, 1'b1, 1'b0);
        wait_until(acc + 1016); chk_state("dn_c1016", 24'hFDFF01, 1'b1, 1'b0);
        wait_until(acc + 1020); chk_state("dn_c1020", 24'hFDFF00, 1'b0, 1'b1);
        repeat (6) @(negedge clk);
        chk_state("dn_hold", 24'hFDFF00, 1'b0, 1'b1);

        // abort at edge 10 of the up-fade
        send(8'h00, 8'h00, 8'h00, 8'd0, 1'b0, 0);
        send(8'd3, 8'd1, 8'd0, 8'd2, 1'b0, -1);
        wait_until(acc + 9);
        cmd_abort = 1'b1;
        @(negedge clk);
        cmd_abort = 1'b0;
        chk_state("abort_c10", 24'h010100, 1'b0, 1'b1);
        repeat (12) @(negedge clk);
        chk_state("abort_hold", 24'h010100, 1'b0, 1'b1);

        // abort on the same edge as the second step
        send(8'h00, 8'h00, 8'h00, 8'd0, 1'b0, 0);
        send(8'd3, 8'd1, 8'd0, 8'd2, 1'b0, -1);
        wait_until(acc + 15);
        cmd_abort = 1'b1;
        @(negedge clk);
        cmd_abort = 1'b0;
        chk_state("abort_step_c16", 24'h010100, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        chk_state("abort_step_hold", 24'h010100, 1'b0, 1'b1);

        // command ignored while fading, then a no-op command
        send(8'd4, 8'd1, 8'd0, 8'd1, 1'b0, 12);
        chk("busy_cmd_ready", {31'h0, cmd_ready}, 32'h0);
        cmd_valid = 1'b1; cmd_r = 8'h50; cmd_g = 8'h50; cmd_b = 8'h50; cmd_rate = 8'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_until(acc + 3);  chk_state("ignore_c3", 24'h010100, 1'b1, 1'b0);
        wait_until(acc + 4);  chk_state("ignore_c4", 24'h020100, 1'b1, 1'b0);
        wait_until(acc + 12); chk_state("ignore_c12", 24'h040100, 1'b0, 1'b1);
        @(negedge clk);
        send(8'd4, 8'd1, 8'd0, 8'd5, 1'b0, 0);
        chk_state("noop_c0", 24'h040100, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        chk_state("noop_c3", 24'h040100, 1'b0, 1'b1);

        // reset mid-fade
        send(8'h40, 8'h00, 8'h00, 8'd0, 1'b0, 0);
        send(8'h80, 8'h00, 8'h00, 8'd1, 1'b0, -1);
        wait_until(acc + 5);
        chk_state("pre_rst", 24'h410000, 1'b1, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_state("in_rst", 24'h000000, 1'b0, 1'b0);
            chk("in_rst_done", {31'h0, done}, 32'h0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk_state("post_rst", 24'h000000, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        chk_state("post_rst_idle", 24'h000000, 1'b0, 1'b1);

        chk("pending_done_events", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rgb_fade_engine.md
# rgb_fade_engine

Colour-fade sequencer that sits directly upstream of the per-channel delta-sigma RGB LED driver. It accepts a target colour and fade rate over a valid/ready command port. It then ramps its three 8-bit channel outputs one LSB at a time toward the target, and those outputs feed the driver's red, green and blue inputs directly. It signals completion with a single-cycle done pulse, so the SPI command front-end can queue the next colour.

## Interface
Parameters:
- TICK_DIV, default 12000: clk cycles per fade tick (1 ms at 12 MHz). Legal range is ≥1. Prescaler width is clog2(TICK_DIV), minimum 1.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine can accept a command
- cmd_r / cmd_g / cmd_b  in  8 each  target channel values
- cmd_rate  in  8  ticks per 1-LSB step; 0 = jump immediately
- cmd_abort  in  1  stop the fade, freeze outputs
- led_r / led_g / led_b  out  8 each  current channel values, to the delta-sigma driver
- busy  out  1  fade in progress
- done  out  1  one-cycle pulse when outputs reach the target

## Operation
- The engine has two states: IDLE and FADE. All outputs are registered.
- **Reset** (rst=1 at an edge):
  - state=IDLE; led_r/g/b=0; busy=0; done=0.
  - Prescaler, tick counter, target registers and rate register are all cleared.
  - cmd_ready=0 while rst=1, then 1 from the first cycle after release.
- **IDLE:**
  - cmd_ready=1. A command is accepted on an edge where cmd_valid=1 and cmd_ready=1. Targets and rate are latched.
  - If cmd_rate=0: led_* take the targets at that edge. done=1 for that one following cycle. State stays IDLE.
  - If cmd_rate>0 and all targets equal the current led_*: done pulses the following cycle. State stays IDLE.
  - Otherwise: go to FADE. Prescaler and tick counter are cleared to 0.
- **FADE:**
  - cmd_ready=0 and busy=1. cmd_valid is ignored; commands are not queued.
  - The prescaler counts 0..TICK_DIV-1 and wraps. The wrap cycle produces a tick.
  - The tick counter counts ticks 0..cmd_rate-1. Its wrap produces a step.
  - On a step, each channel that differs from its target moves ±1 toward it. A channel never overshoots its target, and no wrap-around through 0/255 occurs. Channels already at target hold.
  - The step that makes all three channels equal their targets returns the engine to IDLE. done pulses in the same cycle the final value is visible.
- **Abort:**
  - cmd_abort=1 in FADE: at that edge led_* hold their current values, state becomes IDLE, busy=0, and no done pulse is generated.
  - Abort and step on the same edge: abort wins, and the step is not applied.
  - cmd_abort in IDLE has no effect, even if cmd_valid=1 on the same edge; the command is accepted normally.
- **rst mid-fade** overrides everything: outputs go to 0 and no done pulse is generated.
- Fade duration is max(|target−current|) × cmd_rate × TICK_DIV cycles. The channels are independent, so smaller deltas finish early and hold.

## Timing
- The acceptance edge is defined as cycle 0.
- With rate 0: led_* are valid and done=1 in cycle 1. cmd_ready stays 1, so back-to-back commands are accepted every cycle.
- With rate N>0: step k is visible at cycle k·N·TICK_DIV. busy=1 from cycle 1 until the final step. done=1 and busy=0 in the final-step cycle. cmd_ready=1 in that same cycle, so a new command can be accepted at that edge.
- done is never high for more than one consecutive cycle per command.
- After abort at edge t: busy=0 and cmd_ready=1 in cycle t+1.

## Test plan
Use TICK_DIV=4 for all simulation.
1. **Reset:** hold rst=1 for 3 cycles mid-fade with led_r=0x40 → led_*=0, busy=0, done=0, cmd_ready=0 during reset and 1 on the first cycle after.
2. **Immediate jump:** cmd r=0x80 g=0x10 b=0xFF rate=0 → outputs equal the targets in cycle 1 with done=1 for exactly 1 cycle. A second rate-0 command in cycle 1 is accepted and its values appear in cycle 2.
3. **Up-fade:** from 0, cmd r=3 g=1 b=0 rate=2 → r=1,g=1 at cycle 8; r=2 at 16; r=3 with done=1 and busy=0 at 24. b stays 0 throughout.
4. **Down-fade and saturation:** from r=g=b=0xFF, cmd r=0xFD g=0xFF b=0x00 rate=1 → r reaches 0xFD at cycle 8 then holds. b decrements each 4 cycles, reaching 0x00 at cycle 1020 with done then. No wrap to 0xFF occurs.
5. **Abort:** run test 3 and assert cmd_abort at cycle 10 → led stays r=1 g=1 b=0, no done, and cmd_ready=1 at cycle 11. Abort coincident with the cycle-16 step → r stays 1.
6. **Busy ignore and no-op:** pulse cmd_valid during FADE → no effect on targets. Then in IDLE, send a cmd equal to the current led_* with rate=5 → done in cycle 1 and busy never asserted.
